// File: rtl/c_decoder_seq.sv
// Registered N-to-2^N one-hot decoder: level, timed-pulse and rotate modes, with a disable input.
// Outputs update one edge after inputs are sampled; load is ignored while a pulse is in progress.
module c_decoder_seq #(
  parameter  int SEL_W        = 3,
  parameter  int PULSE_CYCLES = 1,
  localparam int N            = 1 << SEL_W,
  localparam int CW           = $clog2(PULSE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dis,
  input  logic             load,
  input  logic [SEL_W-1:0] sel,
  input  logic [1:0]       mode,
  input  logic             step,
  output logic [N-1:0]     out,
  output logic [SEL_W-1:0] idx,
  output logic             valid,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LEVEL, PULSE, ROTATE} state_t;

  state_t           state, state_nx;
  logic [SEL_W-1:0] idx_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [N-1:0]     out_nx;
  logic             valid_nx, busy_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      out   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      out   <= out_nx;
      valid <= valid_nx;
      busy  <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    if (dis) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (state == PULSE) begin
      // Counter holds the number of cycles still to run after the current one.
      if (cnt == '0) state_nx = IDLE;
      else           cnt_nx   = cnt - CW'(1);
    end else if (load) begin
      idx_nx = sel;
      unique case (mode)
        2'b01: begin
          state_nx = PULSE;
          cnt_nx   = CW'(PULSE_CYCLES - 1);
        end
        2'b10:   state_nx = ROTATE;
        default: state_nx = LEVEL;
      endcase
    end else if (state == ROTATE && step) begin
      idx_nx = idx + SEL_W'(1);
    end

    // Outputs are derived from next-state values so they come straight out of flops.
    valid_nx = (state_nx != IDLE);
    busy_nx  = (state_nx == PULSE);
    out_nx   = valid_nx ? (N'(1) << idx_nx) : '0;
  end

endmodule

// File: tb/tb_c_decoder_seq.sv
// Directed scoreboard bench for c_decoder_seq plus randomised one-hot invariant checks at SEL_W 2 and 4.
module tb_c_decoder_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       dis, load, step;
  logic [2:0] sel;
  logic [1:0] mode;
  logic [7:0] out;
  logic [2:0] idx;
  logic       valid, busy;

  logic        r_dis, r_load, r_step;
  logic [1:0]  r_mode;
  logic [1:0]  sel2, idx2;
  logic [3:0]  out2, sel4, idx4;
  logic [15:0] out4;
  logic        valid2, busy2, valid4, busy4;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [7:0] o;
    logic [2:0] i;
    logic       v;
    logic       b;
    logic       ci;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  c_decoder_seq #(.SEL_W(3), .PULSE_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .dis(dis), .load(load), .sel(sel), .mode(mode), .step(step),
    .out(out), .idx(idx), .valid(valid), .busy(busy)
  );

  c_decoder_seq #(.SEL_W(2), .PULSE_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset), .dis(r_dis), .load(r_load), .sel(sel2), .mode(r_mode), .step(r_step),
    .out(out2), .idx(idx2), .valid(valid2), .busy(busy2)
  );

  c_decoder_seq #(.SEL_W(4), .PULSE_CYCLES(5)) dut4 (
    .clk(clk), .reset(reset), .dis(r_dis), .load(r_load), .sel(sel4), .mode(r_mode), .step(r_step),
    .out(out4), .idx(idx4), .valid(valid4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, record the expected registered response, clock, then score it.
  task automatic cyc(input string tag, input logic ld, input logic ds, input logic [2:0] s,
                     input logic [1:0] m, input logic st, input logic [7:0] eo,
                     input logic [2:0] ei, input logic ev, input logic eb, input logic ci);
    exp_t e;
    load = ld; dis = ds; sel = s; mode = m; step = st;
    e.o = eo; e.i = ei; e.v = ev; e.b = eb; e.ci = ci;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".out"}, 32'(out), 32'(e.o));
    check({tag, ".valid"}, 32'(valid), 32'(e.v));
    check({tag, ".busy"}, 32'(busy), 32'(e.b));
    if (e.ci) check({tag, ".idx"}, 32'(idx), 32'(e.i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {dis, load, step, sel, mode} = '0;
    {r_dis, r_load, r_step, r_mode, sel2, sel4} = '0;
    #12;
    check("rst.out", 32'(out), 0);
    check("rst.idx", 32'(idx), 0);
    check("rst.valid", 32'(valid), 0);
    check("rst.busy", 32'(busy), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Level mode: hold, then disable.
    cyc("lvl.load", 1, 0, 3'd5, 2'b00, 0, 8'h20, 3'd5, 1, 0, 1);
    for (int k = 0; k < 10; k++) cyc("lvl.hold", 0, 0, 3'd0, 2'b00, 0, 8'h20, 3'd5, 1, 0, 1);
    cyc("lvl.dis", 0, 1, 3'd0, 2'b00, 0, 8'h00, 3'd0, 0, 0, 0);

    // Pulse of three cycles; loads during busy ignored, load right after accepted.
    cyc("pls.c1", 1, 0, 3'd2, 2'b01, 0, 8'h04, 3'd2, 1, 1, 1);
    cyc("pls.c2", 1, 0, 3'd7, 2'b00, 0, 8'h04, 3'd2, 1, 1, 1);
    cyc("pls.c3", 1, 0, 3'd6, 2'b00, 0, 8'h04, 3'd2, 1, 1, 1);
    cyc("pls.end", 0, 0, 3'd0, 2'b00, 0, 8'h00, 3'd0, 0, 0, 0);
    cyc("pls.next", 1, 0, 3'd1, 2'b00, 0, 8'h02, 3'd1, 1, 0, 1);
    cyc("lvl.reload", 1, 0, 3'd4, 2'b00, 0, 8'h10, 3'd4, 1, 0, 1);
    cyc("lvl.dis2", 0, 1, 3'd0, 2'b00, 0, 8'h00, 3'd0, 0, 0, 0);

    // Rotate with wrap, load beats step, disable, step ignored in IDLE.
    cyc("rot.load", 1, 0, 3'd6, 2'b10, 0, 8'h40, 3'd6, 1, 0, 1);
    cyc("rot.s1", 0, 0, 3'd0, 2'b00, 1, 8'h80, 3'd7, 1, 0, 1);
    cyc("rot.s2", 0, 0, 3'd0, 2'b00, 1, 8'h01, 3'd0, 1, 0, 1);
    cyc("rot.s3", 0, 0, 3'd0, 2'b00, 1, 8'h02, 3'd1, 1, 0, 1);
    cyc("rot.ldstep", 1, 0, 3'd3, 2'b10, 1, 8'h08, 3'd3, 1, 0, 1);
    cyc("rot.hold", 0, 0, 3'd0, 2'b00, 0, 8'h08, 3'd3, 1, 0, 1);
    cyc("rot.s4", 0, 0, 3'd0, 2'b00, 1, 8'h10, 3'd4, 1, 0, 1);
    cyc("rot.dis", 0, 1, 3'd0, 2'b00, 1, 8'h00, 3'd0, 0, 0, 0);
    cyc("idle.step", 0, 0, 3'd0, 2'b00, 1, 8'h00, 3'd0, 0, 0, 0);
    cyc("idle.ldis", 1, 1, 3'd5, 2'b00, 0, 8'h00, 3'd0, 0, 0, 0);

    // Mode 11 acts as level; step has no effect outside rotate.
    cyc("m3.load", 1, 0, 3'd0, 2'b11, 0, 8'h01, 3'd0, 1, 0, 1);
    cyc("m3.step", 0, 0, 3'd0, 2'b00, 1, 8'h01, 3'd0, 1, 0, 1);
    cyc("m3.dis", 0, 1, 3'd0, 2'b00, 0, 8'h00, 3'd0, 0, 0, 0);

    // Disable aborts a pulse.
    cyc("abort.load", 1, 0, 3'd4, 2'b01, 0, 8'h10, 3'd4, 1, 1, 1);
    cyc("abort.dis", 0, 1, 3'd0, 2'b00, 0, 8'h00, 3'd0, 0, 0, 0);

    // Asynchronous reset in the middle of a pulse.
    cyc("ar.c1", 1, 0, 3'd2, 2'b01, 0, 8'h04, 3'd2, 1, 1, 1);
    cyc("ar.c2", 0, 0, 3'd0, 2'b00, 0, 8'h04, 3'd2, 1, 1, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar.out", 32'(out), 0);
    check("ar.idx", 32'(idx), 0);
    check("ar.valid", 32'(valid), 0);
    check("ar.busy", 32'(busy), 0);
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    check("ar.post", 32'(out), 0);
    cyc("ar.reload", 1, 0, 3'd3, 2'b00, 0, 8'h08, 3'd3, 1, 0, 1);

    // Randomised control at SEL_W 2 and 4: output always equals the decode of idx or zero.
    for (int k = 0; k < 400; k++) begin
      r_load = ($urandom_range(0, 9) < 3);
      r_dis  = ($urandom_range(0, 9) == 0);
      r_step = $urandom_range(0, 1) == 1;
      r_mode = 2'($urandom);
      sel2   = 2'($urandom);
      sel4   = 4'($urandom);
      @(posedge clk); #1;
      check("rnd2.onehot", 32'(out2), valid2 ? 32'(4'b1 << idx2) : 32'd0);
      check("rnd2.valid", 32'(valid2), 32'(out2 != 4'd0));
      check("rnd4.onehot", 32'(out4), valid4 ? 32'(16'b1 << idx4) : 32'd0);
      check("rnd4.valid", 32'(valid4), 32'(out4 != 16'd0));
      check("rnd4.busy", 32'(busy4 & ~valid4), 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
